// File: rtl/iecdrv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_pkg                                                   |
// | Description : Shared constants and helpers for the multi-drive ROM         |
// |               arbiter: drive-count limit, sequencer/slot index widths and  |
// |               parameter range checks used at elaboration.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package iecdrv_pkg;

    localparam int MAX_DRIVES  = 8;
    localparam int MIN_ROM_LAT = 1;
    localparam int MAX_ROM_LAT = 3;

    // Sequencer width: counts 0..LAST where LAST = drives + rom_lat.
    function automatic int seq_w(input int drives, input int rom_lat);
        return $clog2(drives + rom_lat + 1);
    endfunction

    // Slot index width; a single-drive build still needs a 1-bit index.
    function automatic int slot_w(input int drives);
        return (drives > 1) ? $clog2(drives) : 1;
    endfunction

    function automatic bit drives_ok(input int drives);
        return (drives >= 1) && (drives <= MAX_DRIVES);
    endfunction

    function automatic bit rom_lat_ok(input int rom_lat);
        return (rom_lat >= MIN_ROM_LAT) && (rom_lat <= MAX_ROM_LAT);
    endfunction

endpackage : iecdrv_pkg
`default_nettype wire

// File: rtl/iecdrv_slot_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_slot_seq                                              |
// | Description : Slot sequencer for the shared ROM port. A counter restarted  |
// |               by ph2_f walks 0..LAST and saturates there (idle). Decodes   |
// |               which drive owns the address phase and the capture phase.    |
// | Ports       : clk, reset_n   - clock, async active-low reset               |
// |               ph2_f          - restart pulse                               |
// |               addr_slot/hit  - drive whose address is loaded this clk      |
// |               cap_slot/hit   - drive whose ROM data is captured this clk   |
// |               seq_busy       - a ph2_f now would abort pending captures    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module iecdrv_slot_seq
    import iecdrv_pkg::*;
#(
    parameter int DRIVES  = 4,
    parameter int ROM_LAT = 2,
    parameter int SLOT_W  = slot_w(DRIVES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ph2_f,
    output logic [SLOT_W-1:0] addr_slot,
    output logic              addr_hit,
    output logic [SLOT_W-1:0] cap_slot,
    output logic              cap_hit,
    output logic              seq_busy
);

    localparam int              SEQ_W       = seq_w(DRIVES, ROM_LAT);
    localparam int              c_last      = DRIVES + ROM_LAT;
    localparam logic [SEQ_W-1:0] c_last_v   = SEQ_W'(c_last);
    localparam logic [SEQ_W-1:0] c_final_v  = SEQ_W'(c_last - 1);

    logic [SEQ_W-1:0] seq_q, seq_d;
    // Final-slot capture flag: the last drive is captured in the clk after
    // seq == LAST-1, regardless of whether that clk is the idle state or the
    // first state of a sequence restarted by ph2_f. This also keeps the idle
    // state from capturing repeatedly.
    logic             last_q, last_d;

    always_comb begin
        seq_d = seq_q;
        if (ph2_f) begin
            seq_d = '0;
        end else if (seq_q != c_last_v) begin
            seq_d = seq_q + 1'b1;
        end
        last_d = (seq_q == c_final_v);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q  <= c_last_v;
            last_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        addr_slot = '0;
        addr_hit  = 1'b0;
        for (int k = 0; k < DRIVES; k++) begin
            if (seq_q == SEQ_W'(k)) begin
                addr_slot = SLOT_W'(k);
                addr_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        cap_slot = '0;
        cap_hit  = 1'b0;
        // Drives 0..DRIVES-2 capture at seq == k+ROM_LAT+1 (always < LAST).
        for (int k = 0; k < DRIVES - 1; k++) begin
            if (seq_q == SEQ_W'(k + ROM_LAT + 1)) begin
                cap_slot = SLOT_W'(k);
                cap_hit  = 1'b1;
            end
        end
        if (last_q) begin
            cap_slot = SLOT_W'(DRIVES - 1);
            cap_hit  = 1'b1;
        end
    end

    assign seq_busy = (seq_q < c_final_v);

endmodule : iecdrv_slot_seq
`default_nettype wire

// File: rtl/iecdrv_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_rom_arbiter                                           |
// | Description : Time-sliced arbiter sharing one synchronous standard/alt ROM |
// |               read port among DRIVES drive CPUs within one ph2 cycle.      |
// | Ports       : clk, reset_n       - clock, async active-low reset           |
// |               ph2_f              - starts a slot sequence                  |
// |               slot_en            - per-drive enable                        |
// |               drv_addr, rom_mask - packed drive addresses, fold mask       |
// |               stdrom             - select standard (1) or alternate ROM    |
// |               rom_addr           - registered address to both ROMs         |
// |               rom_std_q/alt_q    - ROM read data                           |
// |               drv_data/drv_valid - captured data and capture strobes       |
// |               overrun/_clr       - sticky early-ph2_f flag and its clear   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module iecdrv_rom_arbiter
    import iecdrv_pkg::*;
#(
    parameter int DRIVES  = 4,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ph2_f,
    input  logic [DRIVES-1:0]        slot_en,
    input  logic [DRIVES*ADDR_W-1:0] drv_addr,
    input  logic [ADDR_W-1:0]        rom_mask,
    input  logic                     stdrom,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_std_q,
    input  logic [DATA_W-1:0]        rom_alt_q,
    output logic [DRIVES*DATA_W-1:0] drv_data,
    output logic [DRIVES-1:0]        drv_valid,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int SLOT_W = slot_w(DRIVES);

    if (!drives_ok(DRIVES)) begin : g_bad_drives
        $error("iecdrv_rom_arbiter: DRIVES must be in 1..8");
    end
    if (!rom_lat_ok(ROM_LAT)) begin : g_bad_rom_lat
        $error("iecdrv_rom_arbiter: ROM_LAT must be in 1..3");
    end

    logic [SLOT_W-1:0] w_addr_slot;
    logic              w_addr_hit;
    logic [SLOT_W-1:0] w_cap_slot;
    logic              w_cap_hit;
    logic              w_seq_busy;

    iecdrv_slot_seq #(
        .DRIVES  (DRIVES),
        .ROM_LAT (ROM_LAT),
        .SLOT_W  (SLOT_W)
    ) u_slot_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .ph2_f     (ph2_f),
        .addr_slot (w_addr_slot),
        .addr_hit  (w_addr_hit),
        .cap_slot  (w_cap_slot),
        .cap_hit   (w_cap_hit),
        .seq_busy  (w_seq_busy)
    );

    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [DRIVES*DATA_W-1:0] drv_data_q, drv_data_d;
    logic                     overrun_q, overrun_d;
    logic [DATA_W-1:0]        w_rom_q;

    // ROM select and mask are applied live, so a mid-sequence change only
    // affects slots whose phase has not yet come up.
    assign w_rom_q = stdrom ? rom_std_q : rom_alt_q;

    always_comb begin
        rom_addr_d = rom_addr_q;
        for (int k = 0; k < DRIVES; k++) begin
            if (w_addr_hit && (w_addr_slot == SLOT_W'(k))) begin
                rom_addr_d = drv_addr[k*ADDR_W +: ADDR_W] & rom_mask;
            end
        end
    end

    // The strobe is asserted in the capture clk itself, i.e. alongside the
    // data being registered into drv_data.
    always_comb begin
        drv_data_d = drv_data_q;
        drv_valid  = '0;
        for (int k = 0; k < DRIVES; k++) begin
            if (w_cap_hit && (w_cap_slot == SLOT_W'(k))) begin
                if (slot_en[k]) begin
                    drv_data_d[k*DATA_W +: DATA_W] = w_rom_q;
                    drv_valid[k]                   = 1'b1;
                end else begin
                    // A drive held in reset sees an open bus.
                    drv_data_d[k*DATA_W +: DATA_W] = '1;
                end
            end
        end
    end

    // A restart landing on seq == LAST-1 still gets its final capture, so
    // only earlier restarts count as overrun. Set wins over clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (ph2_f && w_seq_busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            drv_data_q <= '1;
            overrun_q  <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            drv_data_q <= drv_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign drv_data = drv_data_q;
    assign overrun  = overrun_q;

endmodule : iecdrv_rom_arbiter
`default_nettype wire

// File: tb/tb_iecdrv_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_iecdrv_rom_arbiter                                        |
// | Description : Directed self-checking bench. Main instance at defaults      |
// |               (4 drives, latency 2) plus 8/3 and 1/1 instances for         |
// |               capture-timing checks. ROM models: std q = addr[7:0],        |
// |               alt q = addr[7:0] ^ 0xA5, delayed by the instance latency.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_iecdrv_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ph2_f;
    logic        stdrom;
    logic        overrun_clr;
    logic [14:0] rom_mask;

    // main instance: DRIVES=4, ROM_LAT=2
    logic [3:0]  slot_en;
    logic [59:0] drv_addr;
    logic [14:0] rom_addr;
    logic [7:0]  m_std, m_alt;
    logic [31:0] drv_data;
    logic [3:0]  drv_valid;
    logic        overrun;

    // wide instance: DRIVES=8, ROM_LAT=3
    logic [119:0] drv_addr8;
    logic [14:0]  rom_addr8;
    logic [7:0]   w_std, w_alt;
    logic [63:0]  drv_data8;
    logic [7:0]   drv_valid8;
    logic         overrun8;

    // single instance: DRIVES=1, ROM_LAT=1
    logic [14:0] rom_addr1;
    logic [7:0]  s_std, s_alt;
    logic [7:0]  drv_data1;
    logic [0:0]  drv_valid1;
    logic        overrun1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    iecdrv_rom_arbiter dut (
        .clk (clk), .reset_n (reset_n), .ph2_f (ph2_f), .slot_en (slot_en),
        .drv_addr (drv_addr), .rom_mask (rom_mask), .stdrom (stdrom),
        .rom_addr (rom_addr), .rom_std_q (m_std), .rom_alt_q (m_alt),
        .drv_data (drv_data), .drv_valid (drv_valid), .overrun (overrun),
        .overrun_clr (overrun_clr)
    );

    iecdrv_rom_arbiter #(.DRIVES(8), .ADDR_W(15), .DATA_W(8), .ROM_LAT(3)) dut8 (
        .clk (clk), .reset_n (reset_n), .ph2_f (ph2_f), .slot_en (8'hFF),
        .drv_addr (drv_addr8), .rom_mask (rom_mask), .stdrom (stdrom),
        .rom_addr (rom_addr8), .rom_std_q (w_std), .rom_alt_q (w_alt),
        .drv_data (drv_data8), .drv_valid (drv_valid8), .overrun (overrun8),
        .overrun_clr (overrun_clr)
    );

    iecdrv_rom_arbiter #(.DRIVES(1), .ADDR_W(15), .DATA_W(8), .ROM_LAT(1)) dut1 (
        .clk (clk), .reset_n (reset_n), .ph2_f (ph2_f), .slot_en (1'b1),
        .drv_addr (15'h005A), .rom_mask (rom_mask), .stdrom (stdrom),
        .rom_addr (rom_addr1), .rom_std_q (s_std), .rom_alt_q (s_alt),
        .drv_data (drv_data1), .drv_valid (drv_valid1), .overrun (overrun1),
        .overrun_clr (overrun_clr)
    );

    // ROM models with the matching number of register stages
    logic [7:0] m_p1, m_q;
    logic [7:0] w_p1, w_p2, w_q;
    logic [7:0] s_q;
    always @(posedge clk) begin
        m_p1 <= rom_addr[7:0];
        m_q  <= m_p1;
        w_p1 <= rom_addr8[7:0];
        w_p2 <= w_p1;
        w_q  <= w_p2;
        s_q  <= rom_addr1[7:0];
    end
    assign m_std = m_q;
    assign m_alt = m_q ^ 8'hA5;
    assign w_std = w_q;
    assign w_alt = w_q ^ 8'hA5;
    assign s_std = s_q;
    assign s_alt = s_q ^ 8'hA5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one clk after the ph2_f pulse: the clk where seq == 0.
    task automatic pulse_ph2();
        ph2_f = 1'b1;
        tick(1);
        ph2_f = 1'b0;
    endtask

    // Expected main-instance strobes at offset j from seq == 0.
    function automatic logic [3:0] exp_valid4(input int j, input logic [3:0] en);
        logic [3:0] v;
        v = 4'h0;
        if (j >= 3 && j <= 6) v = 4'(1 << (j - 3));
        return v & en;
    endfunction

    initial begin
        reset_n     = 1'b0;
        ph2_f       = 1'b0;
        stdrom      = 1'b1;
        overrun_clr = 1'b0;
        rom_mask    = 15'h7FFF;
        slot_en     = 4'hF;
        drv_addr    = {15'h4040, 15'h3030, 15'h2020, 15'h1010};
        for (int k = 0; k < 8; k++) drv_addr8[k*15 +: 15] = 15'(k * 256 + 129 + k);

        // ---------------- reset / idle ----------------
        tick(3);
        reset_n = 1'b1;
        tick(50);
        chk("reset_data",    drv_data,  64'hFFFF_FFFF);
        chk("reset_valid",   drv_valid, 64'h0);
        chk("reset_romaddr", rom_addr,  64'h0);
        chk("reset_overrun", overrun,   64'h0);

        // ---------------- basic sweep ----------------
        pulse_ph2();
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("sweep_valid_j%0d", j), drv_valid, exp_valid4(j, 4'hF));
            if (j == 1) chk("sweep_romaddr_s0", rom_addr, 64'h1010);
            tick(1);
        end
        chk("sweep_data",    drv_data, 64'h4030_2010);
        chk("sweep_overrun", overrun,  64'h0);
        tick(8);

        // ---------------- masking and ROM select ----------------
        drv_addr[14:0] = 15'h7ABC;
        rom_mask       = 15'h1FFF;
        stdrom         = 1'b0;
        pulse_ph2();
        tick(1);
        chk("mask_romaddr", rom_addr, 64'h1ABC);
        tick(2);
        chk("mask_valid0", drv_valid, 64'h1);
        tick(1);
        chk("alt_data0", drv_data[7:0], 64'h19);
        tick(12);
        stdrom = 1'b1;
        pulse_ph2();
        tick(4);
        chk("std_data0", drv_data[7:0], 64'hBC);
        tick(12);

        // ---------------- slot disable ----------------
        drv_addr[14:0] = 15'h1010;
        rom_mask       = 15'h7FFF;
        slot_en        = 4'b1011;
        pulse_ph2();
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("dis_valid_j%0d", j), drv_valid, exp_valid4(j, 4'b1011));
            tick(1);
        end
        chk("dis_data", drv_data, 64'h40FF_2010);
        tick(8);

        // ---------------- overrun ----------------
        slot_en = 4'hF;
        pulse_ph2();
        tick(12);
        drv_addr[59:45] = 15'h4444;
        pulse_ph2();
        tick(3);
        pulse_ph2();
        chk("ovr_set", overrun, 64'h1);
        for (int j = 0; j < 8; j++) begin
            if (j == 0) chk("ovr_d3_kept", drv_data[31:24], 64'h40);
            chk($sformatf("ovr_valid_j%0d", j), drv_valid, exp_valid4(j, 4'hF));
            tick(1);
        end
        chk("ovr_d3_new", drv_data[31:24], 64'h44);
        tick(8);
        pulse_ph2();
        tick(1);
        ph2_f       = 1'b1;
        overrun_clr = 1'b1;
        tick(1);
        ph2_f       = 1'b0;
        overrun_clr = 1'b0;
        chk("ovr_set_wins", overrun, 64'h1);
        tick(12);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 64'h0);

        // ---------------- boundary: ph2_f at seq == LAST-1 ----------------
        drv_addr[59:45] = 15'h4545;
        pulse_ph2();
        tick(5);
        chk("bnd_valid_s5", drv_valid, 64'h4);
        ph2_f = 1'b1;
        tick(1);
        ph2_f = 1'b0;
        chk("bnd_valid_tail", drv_valid, 64'h8);
        chk("bnd_overrun",    overrun,   64'h0);
        tick(1);
        chk("bnd_data3", drv_data[31:24], 64'h45);
        tick(12);

        // ---------------- parameter sweep: 8/3 and 1/1 ----------------
        pulse_ph2();
        for (int j = 0; j < 13; j++) begin
            chk($sformatf("d8_valid_j%0d", j), drv_valid8,
                (j >= 4 && j <= 11) ? 64'(1 << (j - 4)) : 64'h0);
            chk($sformatf("d1_valid_j%0d", j), drv_valid1, (j == 2) ? 64'h1 : 64'h0);
            tick(1);
        end
        chk("d8_data",    drv_data8, 64'h8887_8685_8483_8281);
        chk("d1_data",    drv_data1, 64'h5A);
        chk("d8_overrun", overrun8,  64'h1);
        chk("d1_overrun", overrun1,  64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_iecdrv_rom_arbiter
`default_nettype wire
